// File: rtl/udma_lin_ch_addrgen.sv
// Address/length generator for one uDMA linear channel: an active transfer plus one
// queued shadow transfer, advanced by 1/2/4 bytes per accepted beat.
module udma_lin_ch_addrgen #(
  parameter int L2_AWIDTH_NOAL = 19,
  parameter int TRANS_SIZE     = 20
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_size_i,
  input  logic                      cfg_continuous_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  input  logic                      beat_i,
  input  logic [1:0]                datasize_i,
  output logic [L2_AWIDTH_NOAL-1:0] ch_addr_o,
  output logic [TRANS_SIZE-1:0]     ch_bytes_left_o,
  output logic                      ch_active_o,
  output logic                      ch_pending_o,
  output logic                      ch_event_o
);

  logic [L2_AWIDTH_NOAL-1:0] r_addr, r_start, r_sh_start;
  logic [TRANS_SIZE-1:0]     r_left, r_size, r_sh_size;
  logic                      r_cont, r_sh_cont, r_active, r_pending, r_event;

  logic [2:0]                w_inc3;
  logic [TRANS_SIZE-1:0]     w_inc_len;
  logic [L2_AWIDTH_NOAL-1:0] w_inc_addr;
  logic                      w_beat, w_done, w_en_ok;

  always_comb begin
    w_inc3 = 3'd4;
    case (datasize_i)
      2'd0:    w_inc3 = 3'd1;
      2'd1:    w_inc3 = 3'd2;
      default: w_inc3 = 3'd4;
    endcase
  end

  assign w_inc_len  = TRANS_SIZE'(w_inc3);
  assign w_inc_addr = L2_AWIDTH_NOAL'(w_inc3);

  // beat_i is a one-cycle acceptance strobe from the arbiter with no backpressure;
  // it counts only while the channel is active.
  assign w_beat  = beat_i & r_active;
  assign w_done  = w_beat & (r_left <= w_inc_len);
  assign w_en_ok = cfg_en_i & (cfg_size_i != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr     <= '0;
      r_left     <= '0;
      r_start    <= '0;
      r_size     <= '0;
      r_cont     <= 1'b0;
      r_sh_start <= '0;
      r_sh_size  <= '0;
      r_sh_cont  <= 1'b0;
      r_active   <= 1'b0;
      r_pending  <= 1'b0;
      r_event    <= 1'b0;
    end else begin
      r_event <= 1'b0;
      if (cfg_clr_i) begin
        r_active  <= 1'b0;
        r_pending <= 1'b0;
        r_addr    <= '0;
        r_left    <= '0;
      end else if (w_done) begin
        r_event <= 1'b1;
        if (r_pending) begin
          r_addr    <= r_sh_start;
          r_left    <= r_sh_size;
          r_start   <= r_sh_start;
          r_size    <= r_sh_size;
          r_cont    <= r_sh_cont;
          r_pending <= w_en_ok;
          if (w_en_ok) begin
            r_sh_start <= cfg_startaddr_i;
            r_sh_size  <= cfg_size_i;
            r_sh_cont  <= cfg_continuous_i;
          end
        end else if (w_en_ok) begin
          r_addr  <= cfg_startaddr_i;
          r_left  <= cfg_size_i;
          r_start <= cfg_startaddr_i;
          r_size  <= cfg_size_i;
          r_cont  <= cfg_continuous_i;
        end else if (r_cont) begin
          r_addr <= r_start;
          r_left <= r_size;
        end else begin
          // Address keeps pointing one past the last beat once the channel goes idle.
          r_active <= 1'b0;
          r_left   <= '0;
          r_addr   <= r_addr + w_inc_addr;
        end
      end else begin
        if (w_beat) begin
          r_addr <= r_addr + w_inc_addr;
          r_left <= r_left - w_inc_len;
        end
        if (w_en_ok) begin
          if (!r_active) begin
            r_addr   <= cfg_startaddr_i;
            r_left   <= cfg_size_i;
            r_start  <= cfg_startaddr_i;
            r_size   <= cfg_size_i;
            r_cont   <= cfg_continuous_i;
            r_active <= 1'b1;
          end else if (!r_pending) begin
            r_sh_start <= cfg_startaddr_i;
            r_sh_size  <= cfg_size_i;
            r_sh_cont  <= cfg_continuous_i;
            r_pending  <= 1'b1;
          end
        end
      end
    end
  end

  assign ch_addr_o       = r_addr;
  assign ch_bytes_left_o = r_left;
  assign ch_active_o     = r_active;
  assign ch_pending_o    = r_pending;
  assign ch_event_o      = r_event;

endmodule
